shift_sequencer: RTL and testbench

Multi-cycle shift engine built around a single-step shift register. It accepts an operand, a shift amount and a shift mode over a valid/ready handshake. It then steps the operand one bit position per clock until the amount is exhausted, and presents the result over a second valid/ready handshake. It serves as the shared shift unit for the DCE datapaths in place of a wide barrel shifter.

---
 rtl/shift_sequencer_pkg.sv | 19 +
 rtl/shift_step_unit.sv | 45 ++++
 rtl/shift_sequencer.sv | 111 +++++++++++
 tb/tb_shift_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle shift engine.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_ASR = 2'b01,
        MODE_LSL = 2'b10,
        MODE_ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_t;

    localparam int unsigned STEP_WIDE = 4;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-step shifter: moves the operand by 1 or STEP_WIDE bit positions.
module shift_step_unit
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic [WIDTH-1:0] d_i,
    input  shift_mode_t      mode_i,
    input  logic             wide_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] step1;
    logic [WIDTH-1:0] step4;

    always_comb begin
        step1 = '0;
        step4 = '0;
        unique case (mode_i)
            MODE_LSR: begin
                step1 = {1'b0, d_i[WIDTH-1:1]};
                step4 = {{STEP_WIDE{1'b0}}, d_i[WIDTH-1:STEP_WIDE]};
            end
            MODE_ASR: begin
                step1 = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
                step4 = {{STEP_WIDE{d_i[WIDTH-1]}}, d_i[WIDTH-1:STEP_WIDE]};
            end
            MODE_LSL: begin
                step1 = {d_i[WIDTH-2:0], 1'b0};
                step4 = {d_i[WIDTH-1-STEP_WIDE:0], {STEP_WIDE{1'b0}}};
            end
            MODE_ROR: begin
                step1 = {d_i[0], d_i[WIDTH-1:1]};
                step4 = {d_i[STEP_WIDE-1:0], d_i[WIDTH-1:STEP_WIDE]};
            end
            default: begin
                step1 = d_i;
                step4 = d_i;
            end
        endcase
    end

    assign q_o = wide_i ? step4 : step1;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: accepts an operand, steps it until the amount is spent, then hands it out.
// Define SHIFT_SEQUENCER_STEP4_EN to take 4-bit steps while at least 4 positions remain.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam logic [AMT_W-1:0] AmtMax = AMT_W'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    shift_mode_t      mode_q, mode_d;

    logic             step_wide;
    logic [AMT_W-1:0] step_amt;
    logic [WIDTH-1:0] step_data;
    logic [AMT_W-1:0] amt_sat;

    // Only reachable for non-power-of-two widths.
    assign amt_sat = (in_amt > AmtMax) ? AmtMax : in_amt;

`ifdef SHIFT_SEQUENCER_STEP4_EN
    assign step_wide = (rem_q >= AMT_W'(STEP_WIDE));
`else
    assign step_wide = 1'b0;
`endif

    assign step_amt = step_wide ? AMT_W'(STEP_WIDE) : AMT_W'(1);

    shift_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .d_i    (data_q),
        .mode_i (mode_q),
        .wide_i (step_wide),
        .q_o    (step_data)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        if (flush) begin
            // Abort wins over everything, including a pending accept in IDLE.
            state_d = IDLE;
            data_d  = '0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_d  = in_data;
                        mode_d  = shift_mode_t'(in_mode);
                        rem_d   = amt_sat;
                        state_d = (amt_sat == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_d = step_data;
                    rem_d  = rem_q - step_amt;
                    if (rem_q == step_amt) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_LSR;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected results queued at accept, compared at out_valid.
module tb_shift_sequencer;

    localparam int W  = 128;
    localparam int AW = $clog2(W);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic [1:0]    in_mode = 2'b00;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          busy;

    typedef struct {
        logic [W-1:0] data;
        int           cycles;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    shift_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int amt,
                                               input logic [1:0] mode);
        logic [W-1:0] r;
        case (mode)
            2'b00:   r = d >> amt;
            2'b01:   r = $signed(d) >>> amt;
            2'b10:   r = d << amt;
            default: r = (amt == 0) ? d : ((d >> amt) | (d << (W - amt)));
        endcase
        return r;
    endfunction

    function automatic int ref_cycles(input int amt);
`ifdef SHIFT_SEQUENCER_STEP4_EN
        return amt / 4 + amt % 4;
`else
        return amt;
`endif
    endfunction

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [W-1:0] d, input int amt, input logic [1:0] mode);
        exp_t e;
        check("in_ready_before_send", W'(in_ready), W'(1));
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = AW'(amt);
        in_mode  = mode;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_amt   = AW'($urandom);
        in_mode  = 2'($urandom);
        e.data   = ref_shift(d, amt, mode);
        e.cycles = ref_cycles(amt);
        sb.push_back(e);
    endtask

    task automatic receive(input string tag, input int hold);
        exp_t e;
        int   n;
        bit   busy_ok;
        bit   stable_ok;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, W'(0), W'(1));
            return;
        end
        e = sb.pop_front();
        n = 0;
        busy_ok = 1'b1;
        @(negedge clock);
        while (!out_valid && n < 400) begin
            if (!busy) busy_ok = 1'b0;
            n++;
            @(negedge clock);
        end
        if (!busy) busy_ok = 1'b0;
        check({tag, "_latency"}, W'(n), W'(e.cycles));
        check({tag, "_busy"}, W'(busy_ok), W'(1));
        check({tag, "_data"}, out_data, e.data);
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b1 || out_data !== e.data || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        if (hold > 0) check({tag, "_hold_stable"}, W'(stable_ok), W'(1));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, "_back_idle"}, W'({out_valid, busy, in_ready}), W'(3'b001));
    endtask

    initial begin
        exp_t dropped;
        bit   quiet;

        repeat (2) @(negedge clock);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, W'(0));
        check("rst_busy", W'(busy), W'(0));
        reset = 1'b1;
        @(negedge clock);

        send({1'b1, 127'b0}, 3, 2'b01);
        receive("asr3", 0);
        check("asr3_literal", ref_shift({1'b1, 127'b0}, 3, 2'b01), {4'hF, 124'b0});

        @(negedge clock);
        send(W'(1), 127, 2'b10);
        receive("lsl127", 0);
        @(negedge clock);
        send(W'(1), 1, 2'b11);
        receive("ror1", 0);

        @(negedge clock);
        send(W'(32'hDEADBEEF), 0, 2'b00);
        receive("amt0_bp", 5);

        @(negedge clock);
        send({$urandom, $urandom, $urandom, $urandom}, 100, 2'b10);
        repeat (40) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_out_valid", W'(out_valid), W'(0));
        check("rstmid_out_data", out_data, W'(0));
        check("rstmid_in_ready", W'(in_ready), W'(1));
        dropped = sb.pop_back();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 37, 2'b11);
        receive("after_rst", 0);

        @(negedge clock);
        send({$urandom, $urandom, $urandom, $urandom}, 50, 2'b00);
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_state", W'({out_valid, busy, in_ready}), W'(3'b001));
        dropped = sb.pop_back();
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clock);
            if (out_valid || busy) quiet = 1'b0;
        end
        check("flush_no_result", W'(quiet), W'(1));

        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = W'(32'h1234);
        in_amt   = AW'(5);
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_blocks_accept", W'({busy, in_ready}), W'(2'b01));
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (out_valid) quiet = 1'b0;
        end
        check("flush_blocks_result", W'(quiet), W'(1));

        send(W'(16'hFFFF), 11, 2'b00);
        receive("lsr11", 0);
        check("lsr11_literal", ref_shift(W'(16'hFFFF), 11, 2'b00), W'(8'h1F));

        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            send({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, W - 1)),
                 2'($urandom));
            receive("rand", (i % 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
